mult8x8_ctrl: RTL and testbench
===============================

# mult8x8_ctrl

Sequencer for the sequential 8x8 multiplier. It captures two 8-bit operands on `start` and feeds one 4-bit nibble pair per cycle to the external 4x4 multiplier. It drives the shifter's 2-bit `shift_cntr` code and accumulates the shifted 16-bit partial products into the final product. The multiplier and shifter stay external; this block owns only the operand registers, the step FSM and the accumulator.

## Interface
- No parameters. Widths are fixed: 8-bit operands, 16-bit product.
- `clk` in 1: single clock. All state updates on its rising edge.
- `reset_a` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin a multiply. Sampled only in IDLE or DONE.
- `dataa` in 8: operand A, captured on an accepted `start`.
- `datab` in 8: operand B, captured on an accepted `start`.
- `product_in` in 16: shifter output for the current step.
- `mult_a` out 4: selected nibble of captured A, to the 4x4 multiplier.
- `mult_b` out 4: selected nibble of captured B, to the 4x4 multiplier.
- `shift_cntr` out 2: shifter code. 0 = no shift, 1 = shift by 4, 2 = shift by 8. This block never drives 3.
- `product8x8_out` out 16: accumulator. Holds the final product in DONE.
- `busy` out 1: high in CALC.
- `done_flag` out 1: high in DONE.

## Operation
- States are IDLE, CALC and DONE. A 2-bit `step` counter runs inside CALC.
- IDLE or DONE with `start`=1:
  - capture A and B
  - clear the accumulator
  - set `step`=0
  - go to CALC
- Step mapping (`mult_a`, `mult_b`, `shift_cntr`):
  - step 0: A[3:0], B[3:0], 0
  - step 1: A[3:0], B[7:4], 1
  - step 2: A[7:4], B[3:0], 1
  - step 3: A[7:4], B[7:4], 2
- CALC, every cycle:
  - accumulator <= accumulator + `product_in` (16-bit add, no carry-out; the maximum result 0xFE01 never overflows)
  - `step` increments
  - after step 3, go to DONE
- DONE: hold the accumulator and assert `done_flag` until the next accepted `start`. There is no self-return to IDLE.
- `start` during CALC is ignored. Operands are not re-captured and the step sequence continues.
- Outputs in IDLE and DONE use the step-0 mapping (`shift_cntr`=0) from the held operand registers.
- `dataa`/`datab` changes outside an accepted `start` have no effect.
- Outputs are registered state or combinational decode of state, `step` and the operand registers. There is no combinational path from `start` or `product_in` to any output.

## Timing
- Reset (async assert, sync release) clears:
  - state to IDLE and `step` to 0
  - operand registers to 0 and `product8x8_out` to 0
  - `busy`=0 and `done_flag`=0
  - so `mult_a`=0, `mult_b`=0, `shift_cntr`=0
- `start` sampled high at edge k:
  - CALC for cycles k+1 to k+4
  - DONE from edge k+4, so `done_flag` is first high in the cycle after k+4
  - latency is 4 cycles from accept to a valid product
- `product_in` must be valid in the same cycle as the step's `mult_a`/`mult_b`/`shift_cntr`. The external path is purely combinational.
- `start` in DONE restarts directly. `done_flag` drops and `busy` rises in the same cycle.
- `reset_a` asserted mid-CALC aborts immediately. The partial accumulator is lost and there is no `done_flag`.

## Configuration
- `MULT_ZERO_SKIP_EN` defined:
  - on an accepted `start` with `dataa`==0 or `datab`==0, go straight to DONE with the accumulator cleared to 0
  - `done_flag` rises one cycle after accept
  - `busy` never asserts
- Undefined: every multiply takes the full 4-step sequence, zero operands included.

## Structure
- Package `mult_pkg` holds:
  - the state enum (IDLE, CALC, DONE)
  - shift-code constants SHIFT_0=2'd0, SHIFT_4=2'd1, SHIFT_8=2'd2
  - constant NUM_STEPS=4
- One natural sub-module, `mult_accum`: 16-bit register with clear, add-enable and async reset. The FSM, step decode and operand registers stay in the top.

## Test plan
- Reset, then A=0xFF, B=0xFF, `start` for one cycle.
  - `shift_cntr` sequence in CALC is 0,1,1,2
  - `product8x8_out`=0xFE01 with `done_flag`=1 four cycles after accept
- A=0x12, B=0x34 with the real 4x4 multiplier and shifter model.
  - nibble pairs per step are (2,4), (2,3), (1,4), (1,3)
  - result 0x03A8
- `start` re-pulsed with A=0x01 during step 2 of the 0x12*0x34 run → ignored, result still 0x03A8.
- `reset_a` asserted during step 1 → all outputs 0 asynchronously and state IDLE. A new 0x0F*0x10 then yields 0x00F0.
- A=0x00, B=0x5A:
  - with `MULT_ZERO_SKIP_EN`: `done_flag` one cycle after accept, result 0, `busy` never high
  - without it: 4-cycle run, result 0
- `start` in DONE with A=0x80, B=0x02 → `done_flag` drops next cycle, result 0x0100 four cycles after accept.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier sequencer.
// Holds the FSM state enum, shifter codes and the per-step nibble/shift decode.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SHIFT_0   = 2'd0;
    localparam logic [1:0] SHIFT_4   = 2'd1;
    localparam logic [1:0] SHIFT_8   = 2'd2;
    localparam int         NUM_STEPS = 4;
    localparam logic [1:0] LAST_STEP = 2'(NUM_STEPS - 1);

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] shift;
    } step_drive_t;

    // Nibble pair and shifter code presented to the external datapath for a step.
    function automatic step_drive_t step_decode(input logic [1:0] step,
                                                input logic [7:0] op_a,
                                                input logic [7:0] op_b);
        step_drive_t d;
        case (step)
            2'd0:    d = '{a: op_a[3:0], b: op_b[3:0], shift: SHIFT_0};
            2'd1:    d = '{a: op_a[3:0], b: op_b[7:4], shift: SHIFT_4};
            2'd2:    d = '{a: op_a[7:4], b: op_b[3:0], shift: SHIFT_4};
            2'd3:    d = '{a: op_a[7:4], b: op_b[7:4], shift: SHIFT_8};
            default: d = '{a: op_a[3:0], b: op_b[3:0], shift: SHIFT_0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mult8x8_ctrl_if.sv
// Handshake and datapath bundle between the multiplier sequencer and its environment.
// The slave modport is the sequencer; the master modport drives operands and the shifter result.
interface mult8x8_ctrl_if;
    logic        start;
    logic [7:0]  dataa;
    logic [7:0]  datab;
    logic [15:0] product_in;
    logic [3:0]  mult_a;
    logic [3:0]  mult_b;
    logic [1:0]  shift_cntr;
    logic [15:0] product8x8_out;
    logic        busy;
    logic        done_flag;

    modport master (
        output start, dataa, datab, product_in,
        input  mult_a, mult_b, shift_cntr, product8x8_out, busy, done_flag
    );

    modport slave (
        input  start, dataa, datab, product_in,
        output mult_a, mult_b, shift_cntr, product8x8_out, busy, done_flag
    );
endinterface

// File: rtl/mult_accum.sv
// 16-bit product accumulator with synchronous clear, add enable and async active-high reset.
// Clear has priority over add so a restart never mixes in a stale partial product.
module mult_accum (
    input  logic        clk,
    input  logic        reset_a,
    input  logic        clr,
    input  logic        add_en,
    input  logic [15:0] addend,
    output logic [15:0] acc
);

    logic [15:0] acc_r;

    // Accumulator register; the sum wraps at 16 bits, which an 8x8 product never reaches.
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            acc_r <= 16'd0;
        end else if (clr) begin
            acc_r <= 16'd0;
        end else if (add_en) begin
            acc_r <= acc_r + addend;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/mult8x8_ctrl.sv
// Sequencer for a sequential 8x8 multiplier built from an external 4x4 multiplier and shifter.
// Optional build macro: MULT_ZERO_SKIP_EN (zero operand finishes immediately with product 0).
module mult8x8_ctrl
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              reset_a,
    mult8x8_ctrl_if.slave     bus
);

    state_t      state_r;
    logic [1:0]  step_r;
    logic [7:0]  op_a_r;
    logic [7:0]  op_b_r;
    step_drive_t drive_r;
    logic        busy_r;
    logic        done_r;

    logic        accept_s;
    logic        zero_skip_s;
    logic        accum_add_s;
    logic [15:0] accum_s;

    // Start is honoured only outside CALC; zero-skip applies when the build enables it.
    always_comb begin
        if (bus.start && (state_r != CALC)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
`ifdef MULT_ZERO_SKIP_EN
        if ((bus.dataa == 8'd0) || (bus.datab == 8'd0)) begin
            zero_skip_s = 1'b1;
        end else begin
            zero_skip_s = 1'b0;
        end
`else
        zero_skip_s = 1'b0;
`endif
        if (state_r == CALC) begin
            accum_add_s = 1'b1;
        end else begin
            accum_add_s = 1'b0;
        end
    end

    // Step FSM with operand capture; datapath drive is registered one step ahead.
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state_r <= IDLE;
            step_r  <= 2'd0;
            op_a_r  <= 8'd0;
            op_b_r  <= 8'd0;
            drive_r <= '{a: 4'd0, b: 4'd0, shift: SHIFT_0};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        op_a_r  <= bus.dataa;
                        op_b_r  <= bus.datab;
                        step_r  <= 2'd0;
                        drive_r <= step_decode(2'd0, bus.dataa, bus.datab);
                        if (zero_skip_s) begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= CALC;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= state_r;
                        busy_r  <= busy_r;
                        done_r  <= done_r;
                    end
                end
                CALC: begin
                    if (step_r == LAST_STEP) begin
                        state_r <= DONE;
                        step_r  <= 2'd0;
                        drive_r <= step_decode(2'd0, op_a_r, op_b_r);
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        step_r  <= step_r + 2'd1;
                        drive_r <= step_decode(step_r + 2'd1, op_a_r, op_b_r);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    step_r  <= 2'd0;
                    drive_r <= step_decode(2'd0, op_a_r, op_b_r);
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    mult_accum u_accum (
        .clk     (clk),
        .reset_a (reset_a),
        .clr     (accept_s),
        .add_en  (accum_add_s),
        .addend  (bus.product_in),
        .acc     (accum_s)
    );

    assign bus.mult_a         = drive_r.a;
    assign bus.mult_b         = drive_r.b;
    assign bus.shift_cntr     = drive_r.shift;
    assign bus.product8x8_out = accum_s;
    assign bus.busy           = busy_r;
    assign bus.done_flag      = done_r;

endmodule

// File: tb/tb_mult8x8_ctrl.sv
// Directed bench for mult8x8_ctrl with a behavioural 4x4 multiplier and shifter.
// Inputs change 1 time unit after the rising edge; outputs are checked in that same quiet window.
module tb_mult8x8_ctrl;

    logic clk;
    logic reset_a;
    int   checks;
    int   errors;

    mult8x8_ctrl_if bus ();

    mult8x8_ctrl dut (
        .clk     (clk),
        .reset_a (reset_a),
        .bus     (bus)
    );

    // External combinational datapath: 4x4 multiply then shift by 0/4/8.
    logic [7:0] nib_prod;
    assign nib_prod       = {4'd0, bus.mult_a} * {4'd0, bus.mult_b};
    assign bus.product_in = {8'd0, nib_prod} << {bus.shift_cntr, 2'b00};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic check_step(input string tag, input logic [3:0] a, input logic [3:0] b,
                              input logic [1:0] sh);
        check({tag, " pair"}, {8'd0, bus.mult_a, bus.mult_b}, {8'd0, a, b});
        check({tag, " shift"}, {14'd0, bus.shift_cntr}, {14'd0, sh});
        check({tag, " busy"}, {15'd0, bus.busy}, 16'd1);
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        bus.dataa = a;
        bus.datab = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.dataa = 8'hAA;
        bus.datab = 8'h55;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        bus.start = 1'b0;
        bus.dataa = 8'd0;
        bus.datab = 8'd0;
        reset_a   = 1'b1;
        tick();
        tick();
        check("reset mult_a", {12'd0, bus.mult_a}, 16'd0);
        check("reset mult_b", {12'd0, bus.mult_b}, 16'd0);
        check("reset shift", {14'd0, bus.shift_cntr}, 16'd0);
        check("reset product", bus.product8x8_out, 16'd0);
        check("reset busy", {15'd0, bus.busy}, 16'd0);
        check("reset done", {15'd0, bus.done_flag}, 16'd0);
        reset_a = 1'b0;
        tick();

        // 0xFF * 0xFF
        launch(8'hFF, 8'hFF);
        check_step("ff s0", 4'hF, 4'hF, 2'd0); tick();
        check_step("ff s1", 4'hF, 4'hF, 2'd1); tick();
        check_step("ff s2", 4'hF, 4'hF, 2'd1); tick();
        check_step("ff s3", 4'hF, 4'hF, 2'd2); tick();
        check("ff product", bus.product8x8_out, 16'hFE01);
        check("ff done", {15'd0, bus.done_flag}, 16'd1);
        check("ff busy low", {15'd0, bus.busy}, 16'd0);
        check("ff idle shift", {14'd0, bus.shift_cntr}, 16'd0);

        // 0x12 * 0x34 with a start re-pulse (A=0x01) during step 2
        launch(8'h12, 8'h34);
        check("12 done drop", {15'd0, bus.done_flag}, 16'd0);
        check_step("12 s0", 4'h2, 4'h4, 2'd0); tick();
        check_step("12 s1", 4'h2, 4'h3, 2'd1); tick();
        check_step("12 s2", 4'h1, 4'h4, 2'd1);
        launch(8'h01, 8'h34);
        check_step("12 s3", 4'h1, 4'h3, 2'd2); tick();
        check("12 product", bus.product8x8_out, 16'h03A8);
        check("12 done", {15'd0, bus.done_flag}, 16'd1);
        tick();
        check("12 hold", bus.product8x8_out, 16'h03A8);
        check("12 hold mult_a", {12'd0, bus.mult_a}, 16'h0002);

        // Reset during step 1 aborts asynchronously
        launch(8'hFF, 8'hFF);
        tick();
        check_step("abort s1", 4'hF, 4'hF, 2'd1);
        #2 reset_a = 1'b1;
        #1;
        check("abort mult_a", {12'd0, bus.mult_a}, 16'd0);
        check("abort mult_b", {12'd0, bus.mult_b}, 16'd0);
        check("abort shift", {14'd0, bus.shift_cntr}, 16'd0);
        check("abort product", bus.product8x8_out, 16'd0);
        check("abort busy", {15'd0, bus.busy}, 16'd0);
        check("abort done", {15'd0, bus.done_flag}, 16'd0);
        tick();
        #1 reset_a = 1'b0;
        tick();
        check("abort stays idle", {15'd0, bus.busy}, 16'd0);

        // 0x0F * 0x10
        launch(8'h0F, 8'h10);
        check_step("0f s0", 4'hF, 4'h0, 2'd0); tick();
        check_step("0f s1", 4'hF, 4'h1, 2'd1); tick();
        check_step("0f s2", 4'h0, 4'h0, 2'd1); tick();
        check_step("0f s3", 4'h0, 4'h1, 2'd2); tick();
        check("0f product", bus.product8x8_out, 16'h00F0);
        check("0f done", {15'd0, bus.done_flag}, 16'd1);

        // Zero operand
        launch(8'h00, 8'h5A);
`ifdef MULT_ZERO_SKIP_EN
        check("zero busy", {15'd0, bus.busy}, 16'd0);
        check("zero done", {15'd0, bus.done_flag}, 16'd1);
        check("zero product", bus.product8x8_out, 16'd0);
        tick();
        check("zero busy later", {15'd0, bus.busy}, 16'd0);
`else
        check_step("zero s0", 4'h0, 4'hA, 2'd0); tick();
        check_step("zero s1", 4'h0, 4'h5, 2'd1); tick();
        check_step("zero s2", 4'h0, 4'hA, 2'd1); tick();
        check_step("zero s3", 4'h0, 4'h5, 2'd2); tick();
        check("zero done", {15'd0, bus.done_flag}, 16'd1);
        check("zero product", bus.product8x8_out, 16'd0);
`endif

        // Restart from DONE: 0x80 * 0x02
        launch(8'h80, 8'h02);
        check("80 done drop", {15'd0, bus.done_flag}, 16'd0);
        check_step("80 s0", 4'h0, 4'h2, 2'd0); tick();
        check_step("80 s1", 4'h0, 4'h0, 2'd1); tick();
        check_step("80 s2", 4'h8, 4'h2, 2'd1); tick();
        check_step("80 s3", 4'h8, 4'h0, 2'd2); tick();
        check("80 product", bus.product8x8_out, 16'h0100);
        check("80 done", {15'd0, bus.done_flag}, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
